// File: rtl/cgr_kmer_sched_pkg.sv
// Shared types and sizing helpers for the CGR k-mer scheduler.
// Holds the FSM state enum, the symbol encoding and the address/table geometry.
package cgr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READ,
    ST_WRITE,
    ST_DONE,
    ST_CLEAR
  } state_t;

  localparam logic [1:0] SYM_A = 2'b00;
  localparam logic [1:0] SYM_C = 2'b01;
  localparam logic [1:0] SYM_G = 2'b10;
  localparam logic [1:0] SYM_T = 2'b11;

  function automatic int cgr_addr_w(input int data_len);
    return 2 * data_len + 2;
  endfunction

  function automatic int tbl_depth(input int data_len);
    return 1 << (2 * data_len);
  endfunction

endpackage

// File: rtl/cgr_kmer_sched_if.sv
// Symbol, CGR-generator and count-memory signals of the k-mer scheduler.
// master = scheduler side, slave = symbol source / generator / SRAM side.
interface cgr_kmer_sched_if
  import cgr_pkg::*;
#(
  parameter int DATA_LEN  = 3,
  parameter int CNT_W     = 16,
  parameter int SEQ_LEN_W = 16
);
  localparam int AW = cgr_addr_w(DATA_LEN);

  logic                 start;
  logic [SEQ_LEN_W-1:0] seq_len;
  logic                 sym_valid;
  logic [1:0]           sym;
  logic                 sym_ready;
  logic                 cgr_step;
  logic [1:0]           cgr_symbol;
  logic [AW-1:0]        cgr_addr;
  logic [AW-1:0]        mem_addr;
  logic                 mem_rd_en;
  logic [CNT_W-1:0]     mem_rdata;
  logic                 mem_wr_en;
  logic [CNT_W-1:0]     mem_wdata;
  logic                 busy;
  logic                 done;
  logic                 sat_flag;

  modport master (
    input  start, seq_len, sym_valid, sym, cgr_addr, mem_rdata,
    output sym_ready, cgr_step, cgr_symbol, mem_addr, mem_rd_en,
           mem_wr_en, mem_wdata, busy, done, sat_flag
  );

  modport slave (
    output start, seq_len, sym_valid, sym, cgr_addr, mem_rdata,
    input  sym_ready, cgr_step, cgr_symbol, mem_addr, mem_rd_en,
           mem_wr_en, mem_wdata, busy, done, sat_flag
  );

endinterface

// File: rtl/cgr_kmer_sched_sat_inc.sv
// Combinational saturating +1 for a count word; sat_o flags an all-ones input.
// Zero latency, no handshake.
module cgr_sat_inc #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o,
  output logic         sat_o
);

  assign sat_o = &a_i;
  assign y_o   = sat_o ? a_i : a_i + W'(1);

endmodule

// File: rtl/cgr_kmer_sched.sv
// K-mer scheduler: one CGR step per symbol, then RMW saturating increment of the count table.
// 1 cycle per warm-up symbol, 3 per counted symbol; sym_ready only in FETCH. CGR_CLEAR_EN zeroes the table per run.
module cgr_kmer_sched
  import cgr_pkg::*;
#(
  parameter int DATA_LEN  = 3,
  parameter int CNT_W     = 16,
  parameter int SEQ_LEN_W = 16
) (
  input logic              CLK,
  input logic              RST,
  cgr_kmer_sched_if.master bus
);

  localparam int AW = cgr_addr_w(DATA_LEN);
  localparam logic [SEQ_LEN_W-1:0] WARM_LEN = SEQ_LEN_W'(DATA_LEN);

  state_t               state_q, state_d;
  logic [SEQ_LEN_W-1:0] seq_len_q, seq_len_d;
  logic [SEQ_LEN_W-1:0] sym_cnt_q, sym_cnt_d, sym_cnt_inc;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 sat_q, sat_d;

  logic                 sym_ready, cgr_step, mem_rd_en, mem_wr_en, done;
  logic [1:0]           cgr_symbol;
  logic [AW-1:0]        mem_addr;
  logic [CNT_W-1:0]     mem_wdata;
  logic [CNT_W-1:0]     inc_val;
  logic                 inc_sat;

`ifdef CGR_CLEAR_EN
  localparam int IW    = 2 * DATA_LEN;
  localparam int DEPTH = tbl_depth(DATA_LEN);
  logic [IW-1:0] clr_idx_q, clr_idx_d;
`endif

  cgr_sat_inc #(.W(CNT_W)) u_sat_inc (
    .a_i   (bus.mem_rdata),
    .y_o   (inc_val),
    .sat_o (inc_sat)
  );

  assign sym_cnt_inc = sym_cnt_q + SEQ_LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    seq_len_d  = seq_len_q;
    sym_cnt_d  = sym_cnt_q;
    addr_d     = addr_q;
    sat_d      = sat_q;
    sym_ready  = 1'b0;
    cgr_step   = 1'b0;
    cgr_symbol = 2'b00;
    mem_addr   = '0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_wdata  = '0;
    done       = 1'b0;
`ifdef CGR_CLEAR_EN
    clr_idx_d  = clr_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          seq_len_d = bus.seq_len;
          sym_cnt_d = '0;
          sat_d     = 1'b0;
`ifdef CGR_CLEAR_EN
          clr_idx_d = '0;
          state_d   = ST_CLEAR;
`else
          state_d   = (bus.seq_len == '0) ? ST_DONE : ST_FETCH;
`endif
        end
      end
`ifdef CGR_CLEAR_EN
      ST_CLEAR: begin
        // Table index i maps onto the CGR layout {0, y, 0, x}.
        mem_wr_en = 1'b1;
        mem_addr  = {1'b0, clr_idx_q[IW-1:DATA_LEN], 1'b0, clr_idx_q[DATA_LEN-1:0]};
        clr_idx_d = clr_idx_q + IW'(1);
        if (clr_idx_q == IW'(DEPTH - 1)) begin
          state_d = (seq_len_q == '0) ? ST_DONE : ST_FETCH;
        end
      end
`endif
      ST_FETCH: begin
        sym_ready  = 1'b1;
        cgr_symbol = bus.sym;
        if (bus.sym_valid) begin
          cgr_step  = 1'b1;
          sym_cnt_d = sym_cnt_inc;
          if (sym_cnt_inc >= WARM_LEN) begin
            state_d = ST_READ;
          end else if (sym_cnt_inc == seq_len_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        // cgr_addr already reflects the step issued last cycle.
        mem_addr  = bus.cgr_addr;
        addr_d    = bus.cgr_addr;
        mem_rd_en = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        mem_addr  = addr_q;
        mem_wr_en = 1'b1;
        mem_wdata = inc_val;
        if (inc_sat) begin
          sat_d = 1'b1;
        end
        state_d = (sym_cnt_q == seq_len_q) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      seq_len_q <= '0;
      sym_cnt_q <= '0;
      addr_q    <= '0;
      sat_q     <= 1'b0;
`ifdef CGR_CLEAR_EN
      clr_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      seq_len_q <= seq_len_d;
      sym_cnt_q <= sym_cnt_d;
      addr_q    <= addr_d;
      sat_q     <= sat_d;
`ifdef CGR_CLEAR_EN
      clr_idx_q <= clr_idx_d;
`endif
    end
  end

  assign bus.sym_ready  = sym_ready;
  assign bus.cgr_step   = cgr_step;
  assign bus.cgr_symbol = cgr_symbol;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_rd_en  = mem_rd_en;
  assign bus.mem_wr_en  = mem_wr_en;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done;
  assign bus.sat_flag   = sat_q;

endmodule

// File: doc/cgr_kmer_sched.md
Name: cgr_kmer_sched

Overview:
Scheduler that sequences the CGR address generator across a DNA symbol stream and maintains a k-mer frequency table.
- Accepts 2-bit symbols over a valid/ready handshake and issues one CGR step per symbol.
- After a (DATA_LEN-1)-symbol warm-up, performs a read-modify-write saturating increment of the count memory at the generated CGR address.
- Sits between the symbol source, the CGR generator and the count SRAM.

Parameters:
DATA_LEN, 3, k-mer length; CGR axis width; CGR address width is 2*DATA_LEN+2
CNT_W, 16, count word width
SEQ_LEN_W, 16, width of the sequence-length register

Ports:
CLK  input  1  clock
RST  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that launches a run; ignored unless IDLE
seq_len  input  SEQ_LEN_W  number of symbols in the run; latched on start
sym_valid  input  1  symbol available
sym  input  2  symbol, A=00 C=01 G=10 T=11
sym_ready  output  1  scheduler accepts sym this cycle
cgr_step  output  1  one-cycle pulse; CGR generator shifts in cgr_symbol
cgr_symbol  output  2  symbol presented to CGR generator
cgr_addr  input  2*DATA_LEN+2  CGR address; must reflect the step issued in the previous cycle
mem_addr  output  2*DATA_LEN+2  count memory address
mem_rd_en  output  1  read strobe; mem_rdata is valid the next cycle
mem_rdata  input  CNT_W  read data
mem_wr_en  output  1  write strobe
mem_wdata  output  CNT_W  write data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of run
sat_flag  output  1  sticky; some counter saturated this run

Behaviour:
- Reset: state=IDLE; sym_cnt=0; all outputs 0, including mem_addr and cgr_symbol. Memory contents are not touched. Reset mid-run aborts immediately with no further memory write.
- States: IDLE, FETCH, READ, WRITE, DONE.
- IDLE:
  - start=1 latches seq_len, clears sym_cnt and sat_flag.
  - If seq_len==0, go to DONE; else go to FETCH.
- FETCH:
  - sym_ready=1, cgr_symbol=sym (combinational).
  - On sym_valid: cgr_step=1 and sym_cnt++.
  - If the new sym_cnt < DATA_LEN (warm-up), stay in FETCH; else go to READ.
  - With sym_valid=0, wait; no step is issued.
- READ: mem_addr=cgr_addr (registered into an address hold), mem_rd_en=1; then go to WRITE.
- WRITE:
  - mem_addr=held address, mem_wr_en=1.
  - mem_wdata = mem_rdata+1, saturating at 2^CNT_W-1. Saturation (mem_rdata all-ones) sets sat_flag.
  - If sym_cnt==seq_len, go to DONE; else go to FETCH.
- DONE: done=1 for one cycle, then IDLE. sat_flag holds until the next start.
- Throughput: 1 cycle per warm-up symbol; 3 cycles per counted symbol.
- seq_len < DATA_LEN: all symbols consumed as warm-up, no memory access; DONE follows the last accept.
- start while busy is ignored. sym_ready is 0 outside FETCH.
- sym_cnt width is SEQ_LEN_W; no wrap is possible because the run ends at seq_len.

Optional Feature:
CGR_CLEAR_EN.
- Defined: start enters a CLEAR state before FETCH (or before DONE if seq_len==0).
  - Writes 0 to all 4^DATA_LEN table entries, one per cycle.
  - Index i counts 0..4^DATA_LEN-1; mem_addr = {1'b0, i[2*DATA_LEN-1:DATA_LEN], 1'b0, i[DATA_LEN-1:0]}; mem_wr_en=1.
  - sym_ready=0 during CLEAR.
- Undefined: no CLEAR state; counts accumulate across runs.

Decomposition:
- Package cgr_pkg holds:
  - state enum
  - symbol encoding constants
  - CGR_ADDR_W(DATA_LEN) = 2*DATA_LEN+2
  - table depth 4^DATA_LEN
- One sub-module, cgr_sat_inc (combinational CNT_W saturating incrementer with saturation flag), instanced in WRITE datapath.

Test Plan:
- DATA_LEN=3, seq_len=5, A C G T A with sym_valid continuously high, start at cycle 0 -> steps at cycles 1,2,3,6,9; writes at cycles 5,8,11; done at cycle 12; each written value = prior value + 1.
- Same stream with sym_valid deasserted for 4 cycles before symbol 3 -> no cgr_step while stalled; done delayed by exactly 4 cycles; same write data.
- seq_len=2 -> two steps, mem_rd_en/mem_wr_en never asserted; done at cycle 3. seq_len=0 -> done at cycle 1, no steps.
- mem_rdata=16'hFFFF returned on a read -> mem_wdata=16'hFFFF, sat_flag=1 until the next start.
- RST asserted in a READ cycle -> all outputs 0 the same cycle; no write; next start runs normally.
- CGR_CLEAR_EN defined, DATA_LEN=3 -> 64 consecutive zero writes; addresses 8'h00..8'h77 skipping those with bit 7 or bit 3 set; first FETCH at cycle 65.
